// File: rtl/imem_loader.sv
// imem_loader
//   Receives a framed instruction image byte by byte from a serial receiver
//   and writes it word by word into instruction memory. The core is held in
//   reset until a complete image with a matching checksum has been loaded.
//
//   Frame: 8'hA5, count[7:0], count[15:8], count words (4 bytes each,
//   little-endian), then one XOR checksum byte covering all data bytes.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   rx_valid   : upstream byte available
//   rx_data    : upstream byte
//   rx_ready   : loader accepts a byte this cycle (low only while wr_en is high)
//   wr_en      : one-cycle instruction-memory write strobe
//   wr_addr    : byte address of the write
//   wr_data    : instruction word to write
//   core_reset : holds the core in reset while high
//   done       : image loaded and checksum matched
//   error      : image rejected (bad length or checksum)
module imem_loader #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] partial;   // first three bytes of the current word, shifted in from the top
  logic        accept;

  // The write cycle is the only cycle that cannot take a byte.
  assign rx_ready = ~wr_en;
  assign accept   = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      partial    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (wr_en) begin
      // Write cycle: no byte is accepted, so advancing the word index here
      // cannot collide with data handling.
      wr_en    <= 1'b0;
      word_idx <= word_idx + 16'd1;
      if (word_idx == count - 16'd1) begin
        state <= CHECK;
      end
    end else if (accept) begin
      unique case (state)
        IDLE: begin
          if (rx_data == 8'hA5) begin
            state <= LEN_LO;
          end
        end
        LEN_LO: begin
          count[7:0] <= rx_data;
          state      <= LEN_HI;
        end
        LEN_HI: begin
          count[15:8] <= rx_data;
          word_idx    <= '0;
          byte_idx    <= '0;
          csum        <= '0;
          if (({rx_data, count[7:0]} == 16'd0) ||
              ({16'd0, rx_data, count[7:0]} > MEM_WORDS)) begin
            state <= ERROR;
            error <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          csum     <= csum ^ rx_data;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            wr_en   <= 1'b1;
            wr_data <= {rx_data, partial};
            wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
          end else begin
            partial <= {rx_data, partial[23:8]};
          end
        end
        CHECK: begin
          if (rx_data == csum) begin
            state      <= DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
          end else begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
        DONE, ERROR: begin
          if (rx_data == 8'hA5) begin
            state      <= LEN_LO;
            done       <= 1'b0;
            error      <= 1'b0;
            core_reset <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_reset;
  logic        done;
  logic        error;

  imem_loader #(.MEM_WORDS(256), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  gap_max = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int gap;
    int n;
    gap = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
    idle(gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: got rx_ready low for 20 cycles, expected high");
    end
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input bit expect_wr);
    if (expect_wr) exp_q.push_back('{addr: BASE + 32'(4 * idx), data: w});
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic chk_status(input string tag, input logic exp_cr, input logic exp_done, input logic exp_err);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'(exp_cr));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
  endtask

  initial begin
    logic [7:0] cs;
    logic [31:0] w;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", wr_addr, BASE);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk_status("rst", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    // One word 0x00000013, checksum 0x13.
    send(8'hA5); send(8'h01); send(8'h00);
    send_word(32'h0000_0013, 0, 1'b1);
    send(8'h13);
    idle(2);
    chk_status("one_word", 1'b0, 1'b1, 1'b0);

    // Restart from DONE: two words; 93^00^50^00^13^01^A0^00 = 0x71.
    send(8'hA5);
    idle(1);
    chk_status("restart", 1'b1, 1'b0, 1'b0);
    send(8'h02); send(8'h00);
    send_word(32'h0050_0093, 0, 1'b1);
    send_word(32'h00A0_0113, 1, 1'b1);
    send(8'h71);
    idle(2);
    chk_status("two_words", 1'b0, 1'b1, 1'b0);

    // Zero length.
    send(8'hA5); send(8'h00); send(8'h00);
    idle(2);
    chk_status("len_zero", 1'b1, 1'b0, 1'b1);

    // Length 0x0101 exceeds 256 words.
    send(8'hA5);
    idle(1);
    chk_status("err_restart", 1'b1, 1'b0, 1'b0);
    send(8'h01); send(8'h01);
    idle(2);
    chk_status("len_big", 1'b1, 1'b0, 1'b1);

    // Bad checksum: the word is still written.
    send(8'hA5); send(8'h01); send(8'h00);
    send_word(32'h0000_0013, 0, 1'b1);
    send(8'h00);
    idle(2);
    chk_status("bad_csum", 1'b1, 1'b0, 1'b1);

    // Leading junk then two-word frame with random gaps.
    gap_max = 3;
    send(8'h00); send(8'hFF);
    send(8'hA5); send(8'h02); send(8'h00);
    send_word(32'h0050_0093, 0, 1'b1);
    send_word(32'h00A0_0113, 1, 1'b1);
    send(8'h71);
    gap_max = 0;
    idle(2);
    chk_status("gaps", 1'b0, 1'b1, 1'b0);

    // Maximum length: 256 words, last address 0x3FC.
    send(8'hA5); send(8'h00); send(8'h01);
    cs = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i ^ 8'h5A), 8'(i + 3), 8'(255 - i)};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w, i, 1'b1);
    end
    send(cs);
    idle(2);
    chk_status("max_len", 1'b0, 1'b1, 1'b0);

    // From DONE: restart, then reset after two data bytes.
    send(8'hA5);
    idle(1);
    chk_status("pre_abort", 1'b1, 1'b0, 1'b0);
    send(8'h01); send(8'h00);
    send(8'h13); send(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_wr_addr", wr_addr, BASE);
    chk("abort_wr_data", wr_data, 0);
    chk_status("abort", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    // Remaining bytes of the abandoned word must not produce a write.
    send(8'h00); send(8'h00); send(8'h13);
    idle(4);
    chk_status("post_abort", 1'b1, 1'b0, 1'b0);

    chk("pending_writes", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
